// File: rtl/barcode_session_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : barcode_session_ctrl_pkg
//  Brief    : Shared state encoding, pricing defaults and button increments
//             for the barcode session controller.
//  Revision : 1.0 - initial release
// ============================================================================
package barcode_session_ctrl_pkg;

    // Session controller states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCUM    = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_GEN = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Default saturation cap and unit price (cap * price must fit in 6 bits)
    localparam int DEF_MAX_UNITS      = 12;
    localparam int DEF_PRICE_PER_UNIT = 4;

    // Half-hour units added by each button, sized for the 5-bit accumulator sum
    localparam logic [4:0] INC_30MIN   = 5'd1;
    localparam logic [4:0] INC_1HOUR   = 5'd2;
    localparam logic [4:0] INC_2HOURS  = 5'd4;

endpackage
`default_nettype wire

// File: rtl/barcode_session_ctrl_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter2
//  Brief    : Two-requester round-robin arbiter. Grant is combinational; the
//             last-served pointer only moves when a session completes.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       served_i,
    output logic [1:0] grant_o
);

    // 0 = A served last, 1 = B served last; reset to B so A wins first
    logic last_q;

    // Record the client whose session just completed
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (update_i) begin
            last_q <= served_i;
        end
    end

    // Single requester wins outright; on contention the one not served last wins
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/barcode_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : barcode_session_ctrl
//  Brief    : Parking-session controller: grants one of two clients, sums
//             purchased half-hour units from button edges, then hands off to
//             an external barcode generator and reports completion.
//  Revision : 1.0 - initial release
// ============================================================================
module barcode_session_ctrl
    import barcode_session_ctrl_pkg::*;
#(
    parameter int MAX_UNITS      = DEF_MAX_UNITS,
    parameter int PRICE_PER_UNIT = DEF_PRICE_PER_UNIT
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ClientA,
    input  logic       ClientB,
    input  logic       Button30Min,
    input  logic       Button1Hour,
    input  logic       Button2Hours,
    input  logic       Confirm,
    input  logic       GenDone,
    output logic [1:0] ActiveClient,
    output logic [3:0] Units,
    output logic [5:0] ValueToPay,
    output logic       GenStart,
    output logic       GenClient,
    output logic       SessionDone
);

    localparam logic [4:0] c_MAX_UNITS = 5'(MAX_UNITS);
    localparam logic [5:0] c_PRICE     = 6'(PRICE_PER_UNIT);

    state_t      state_q;
    logic [1:0]  active_q;
    logic        gen_client_q;
    logic [3:0]  units_q;
    logic [5:0]  value_q;
    logic        gen_start_q;
    logic        session_done_q;
    logic [2:0]  btn_hist_q;
    logic        confirm_hist_q;

    logic [2:0]  w_btn_edge;
    logic        w_confirm_edge;
    logic [4:0]  w_add;
    logic [4:0]  w_units_sum;
    logic [3:0]  units_d;
    logic [5:0]  value_d;
    logic        w_req_held;
    logic [1:0]  w_grant;
    logic        w_update_ptr;

    // Round-robin choice between the two clients
    rr_arbiter2 u_arb (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .req_i    ({ClientB, ClientA}),
        .update_i (w_update_ptr),
        .served_i (gen_client_q),
        .grant_o  (w_grant)
    );

    // Pointer advances only on a completed session, never on an abort
    assign w_update_ptr = (state_q == ST_DONE);

    // Input history for rising-edge detection; runs in every state so a level
    // already high when a session starts is not counted as a press
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            btn_hist_q     <= 3'b000;
            confirm_hist_q <= 1'b0;
        end else begin
            btn_hist_q     <= {Button2Hours, Button1Hour, Button30Min};
            confirm_hist_q <= Confirm;
        end
    end

    assign w_btn_edge     = {Button2Hours, Button1Hour, Button30Min} & ~btn_hist_q;
    assign w_confirm_edge = Confirm & ~confirm_hist_q;

    // Simultaneous presses add together; the sum saturates at the cap
    assign w_add = ({5{w_btn_edge[0]}} & INC_30MIN)
                 + ({5{w_btn_edge[1]}} & INC_1HOUR)
                 + ({5{w_btn_edge[2]}} & INC_2HOURS);
    assign w_units_sum = {1'b0, units_q} + w_add;
    assign units_d     = (w_units_sum > c_MAX_UNITS) ? c_MAX_UNITS[3:0] : w_units_sum[3:0];

    // Price lags the unit count by one register stage
    assign value_d = {2'b00, units_q} * c_PRICE;

    // The granted client's own request keeps the session alive
    assign w_req_held = (active_q[0] & ClientA) | (active_q[1] & ClientB);

    // Session FSM with all outputs registered
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            active_q       <= 2'b00;
            gen_client_q   <= 1'b0;
            units_q        <= 4'd0;
            value_q        <= 6'd0;
            gen_start_q    <= 1'b0;
            session_done_q <= 1'b0;
        end else begin
            gen_start_q    <= 1'b0;
            session_done_q <= 1'b0;
            value_q        <= value_d;
            case (state_q)
                ST_IDLE: begin
                    if (w_grant != 2'b00) begin
                        active_q     <= w_grant;
                        gen_client_q <= w_grant[1];
                        state_q      <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (!w_req_held) begin
                        state_q  <= ST_IDLE;
                        active_q <= 2'b00;
                        units_q  <= 4'd0;
                        value_q  <= 6'd0;
                    end else begin
                        units_q <= units_d;
                        if (w_confirm_edge && (units_q != 4'd0)) begin
                            state_q     <= ST_ISSUE;
                            gen_start_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT_GEN;
                end
                ST_WAIT_GEN: begin
                    if (GenDone) begin
                        state_q        <= ST_DONE;
                        session_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q  <= ST_IDLE;
                    active_q <= 2'b00;
                    units_q  <= 4'd0;
                    value_q  <= 6'd0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    active_q <= 2'b00;
                    units_q  <= 4'd0;
                    value_q  <= 6'd0;
                end
            endcase
        end
    end

    assign ActiveClient = active_q;
    assign Units        = units_q;
    assign ValueToPay   = value_q;
    assign GenStart     = gen_start_q;
    assign GenClient    = gen_client_q;
    assign SessionDone  = session_done_q;

endmodule
`default_nettype wire

// File: doc/barcode_session_ctrl.md
BARCODE_SESSION_CTRL -- requirements
Module: barcode_session_ctrl

Interface
REQ-001 Parameter MAX_UNITS, default 12: saturation cap on purchased half-hour units.
REQ-002 Parameter PRICE_PER_UNIT, default 4: price per half-hour unit; MAX_UNITS*PRICE_PER_UNIT SHALL be <= 63.
REQ-003 Port Clk, input, 1: single clock; every register is rising-edge.
REQ-004 Port Reset, input, 1: asynchronous, active-high reset.
REQ-005 Ports ClientA / ClientB, input, 1 each: level session requests, already synchronous to Clk.
REQ-006 Ports Button30Min / Button1Hour / Button2Hours, input, 1 each: synchronous button levels adding 1 / 2 / 4 units.
REQ-007 Port Confirm, input, 1: synchronous level; a rising edge requests barcode issue.
REQ-008 Port GenDone, input, 1: one-cycle pulse from the barcode generator.
REQ-009 Port ActiveClient, output, 2: one-hot grant; bit0 = A, bit1 = B, 00 = none.
REQ-010 Port Units, output, 4: accumulated half-hour units.
REQ-011 Port ValueToPay, output, 6: Units*PRICE_PER_UNIT.
REQ-012 Port GenStart, output, 1: one-cycle pulse starting the barcode generator.
REQ-013 Port GenClient, output, 1: client identity for the generator; 0 = A, 1 = B.
REQ-014 Port SessionDone, output, 1: one-cycle pulse when a barcode completes.

Function
REQ-015 The FSM SHALL have the states IDLE, ACCUM, ISSUE, WAIT_GEN and DONE.
REQ-016 IDLE: a request grants in the next cycle and moves to ACCUM; if A and B request together, the client not served last wins (round-robin), and A wins first after reset.
REQ-017 ActiveClient and GenClient SHALL be registered and held constant from grant until the return to IDLE.
REQ-018 Each button SHALL use a rising-edge detector; only edges seen in ACCUM count.
REQ-019 Simultaneous edges in one cycle SHALL sum (for example, 1+2+4 = 7 units).
REQ-020 Units SHALL saturate at MAX_UNITS and never wrap.
REQ-021 ValueToPay SHALL be registered and update one cycle after Units changes.
REQ-022 In ACCUM, a Confirm edge with Units > 0 SHALL move to ISSUE; a Confirm edge with Units = 0 SHALL be ignored.
REQ-023 In ACCUM, deassertion of the granted client's request SHALL abort to IDLE: Units and ValueToPay clear, no GenStart, and the last-served pointer is unchanged.
REQ-024 ISSUE SHALL last exactly one cycle with GenStart = 1, then move to WAIT_GEN.
REQ-025 WAIT_GEN SHALL hold until GenDone, ignoring buttons, Confirm and request drops; GenDone outside WAIT_GEN SHALL be ignored.
REQ-026 DONE SHALL last one cycle with SessionDone = 1 and update the last-served pointer; the FSM then returns to IDLE and clears Units, ValueToPay and ActiveClient.
REQ-027 A request still asserted in IDLE SHALL be arbitrated again, with round-robin applied.

Reset
REQ-028 Reset SHALL force IDLE with ActiveClient = 00, Units = 0, ValueToPay = 0, GenStart = 0, GenClient = 0, SessionDone = 0, edge-detector history = 0 and last-served pointer = B (so A has priority).
REQ-029 Reset asserted in any state, including mid-WAIT_GEN, SHALL take effect immediately; GenDone arriving after reset SHALL be ignored.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, MAX_UNITS, PRICE_PER_UNIT and the per-button unit increments 1/2/4.
REQ-031 A sub-module, rr_arbiter2, SHALL implement the two-requester round-robin grant with a last-served pointer.
REQ-032 Edge detection and unit accumulation SHALL stay in the top module.

Verification
REQ-033 Scenario: Reset; ClientA=1; Button1Hour edge; Button30Min edge; Confirm edge -> ActiveClient=01, Units=3, ValueToPay=12, one GenStart with GenClient=0, and SessionDone one cycle after GenDone.
REQ-034 Scenario: ClientA and ClientB held high through two complete sessions -> the first grant is A, the second is B.
REQ-035 Scenario: the three buttons rise in one cycle, three times -> Units = 7, then 12 (saturated), then 12; ValueToPay = 48.
REQ-036 Scenario: ClientB granted, Units=2, ClientB drops before Confirm -> IDLE, Units=0, ValueToPay=0, no GenStart, and the next simultaneous request is granted to B again.
REQ-037 Scenario: Confirm with Units=0 -> remains in ACCUM with no GenStart; later, GenDone pulsed in IDLE -> no SessionDone.
REQ-038 Scenario: Reset during WAIT_GEN, then GenDone -> all outputs at reset values and no SessionDone.
